// File: rtl/milano_pkg.sv
// Shared types and op-class helpers for the milano EX-stage ALU/MDU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package milano_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_AUIPC  = 5'd10,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_mdu_state_e;

    function automatic logic is_mul(alu_mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(alu_mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(alu_mdu_op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_mdu_div.sv
// Radix-2 restoring divider on unsigned magnitudes; XLEN iterations after start.
// Latency: XLEN cycles after start; done_o flags the final iteration, results are its combinational outcome.
// Backpressure: none; the caller captures on done_o, flush_i abandons the op.
module alu_mdu_div #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    // quot doubles as the dividend shift register; its MSB feeds the partial remainder
    always_comb begin
        rem_sh = {rem, quot[XLEN-1]};
        diff   = rem_sh - {1'b0, dvsr};
        if (!diff[XLEN]) begin
            remainder_o = diff[XLEN-1:0];
            quotient_o  = {quot[XLEN-2:0], 1'b1};
        end else begin
            remainder_o = rem_sh[XLEN-1:0];
            quotient_o  = {quot[XLEN-2:0], 1'b0};
        end
    end

    assign done_o = busy && (cnt == CW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            busy <= 1'b0;
            cnt  <= '0;
            quot <= '0;
            rem  <= '0;
            dvsr <= '0;
        end else if (start_i) begin
            busy <= 1'b1;
            cnt  <= CW'(XLEN);
            quot <= dividend_i;
            rem  <= '0;
            dvsr <= divisor_i;
        end else if (busy) begin
            quot <= quotient_o;
            rem  <= remainder_o;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage integer ALU + M-extension with registered rd write triple; ALU_MDU_DIV_EARLY_EN enables 1-cycle trivial divides.
// Latency: 1 cycle for ALU/AUIPC, MUL_LAT for multiply, XLEN+1 for divide.
// Backpressure: result held in DONE until out_ready_i; a new op is accepted in the release cycle.
module alu_mdu
    import milano_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  alu_mdu_op_e     operate_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [XLEN-1:0] instr_addr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            alu_rd_we_o,
    output logic [4:0]      alu_rd_waddr_o,
    output logic [XLEN-1:0] alu_rd_wdata_o,
    output logic            busy_o
);

    localparam int SHW = $clog2(XLEN);

    alu_mdu_state_e  state;
    alu_mdu_op_e     op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [2:0]      mul_cnt;
    logic            accept;

    assign in_ready_o = !flush_i && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = (state != ST_IDLE);

    // Single-cycle ALU
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_op_ok;

    assign shamt = operand_b_i[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_op_ok = 1'b1;
        case (operate_i)
            OP_ADD:   alu_res = operand_a_i + operand_b_i;
            OP_SUB:   alu_res = operand_a_i - operand_b_i;
            OP_SLL:   alu_res = operand_a_i << shamt;
            OP_SLT:   alu_res = XLEN'($signed(operand_a_i) < $signed(operand_b_i));
            OP_SLTU:  alu_res = XLEN'(operand_a_i < operand_b_i);
            OP_XOR:   alu_res = operand_a_i ^ operand_b_i;
            OP_SRL:   alu_res = operand_a_i >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(operand_a_i) >>> shamt);
            OP_OR:    alu_res = operand_a_i | operand_b_i;
            OP_AND:   alu_res = operand_a_i & operand_b_i;
            OP_AUIPC: alu_res = operand_a_i + instr_addr_i;
            default:  alu_op_ok = 1'b0;
        endcase
    end

    // One multiplier, fed from the inputs at accept or from the held operands while in MUL
    alu_mdu_op_e       mul_op;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic [2*XLEN-1:0] mul_ext_a;
    logic [2*XLEN-1:0] mul_ext_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_op    = (state == ST_MUL) ? op_q : operate_i;
        mul_a     = (state == ST_MUL) ? a_q  : operand_a_i;
        mul_b     = (state == ST_MUL) ? b_q  : operand_b_i;
        mul_ext_a = {{XLEN{(mul_op != OP_MULHU) & mul_a[XLEN-1]}}, mul_a};
        mul_ext_b = {{XLEN{(mul_op == OP_MULH) & mul_b[XLEN-1]}}, mul_b};
        mul_prod  = mul_ext_a * mul_ext_b;
        mul_res   = (mul_op == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Sign fix-up and corner cases applied to the unsigned magnitude results
    function automatic logic [XLEN-1:0] div_fix(alu_mdu_op_e op, logic [XLEN-1:0] a,
                                                logic [XLEN-1:0] b, logic [XLEN-1:0] qm,
                                                logic [XLEN-1:0] rm);
        logic            sgn;
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        sgn = is_signed_div(op);
        q   = (sgn && (a[XLEN-1] ^ b[XLEN-1])) ? -qm : qm;
        r   = (sgn && a[XLEN-1]) ? -rm : rm;
        if (b == '0) begin
            q = '1;
            r = a;
        end
        return (op == OP_REM || op == OP_REMU) ? r : q;
    endfunction

    logic            div_signed_in;
    logic [XLEN-1:0] div_abs_a;
    logic [XLEN-1:0] div_abs_b;
    logic            div_early;
    logic [XLEN-1:0] div_early_res;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;

    assign div_signed_in = is_signed_div(operate_i);
    assign div_abs_a     = (div_signed_in && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
    assign div_abs_b     = (div_signed_in && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;

`ifdef ALU_MDU_DIV_EARLY_EN
    assign div_early = (operand_b_i == '0) || (div_abs_a < div_abs_b);
`else
    assign div_early = 1'b0;
`endif

    assign div_early_res = div_fix(operate_i, operand_a_i, operand_b_i, '0, div_abs_a);
    assign div_start     = accept && is_div(operate_i) && !div_early;

    alu_mdu_div #(
        .XLEN (XLEN)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .start_i     (div_start),
        .dividend_i  (div_abs_a),
        .divisor_i   (div_abs_b),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            out_valid_o    <= 1'b0;
            alu_rd_we_o    <= 1'b0;
            alu_rd_waddr_o <= '0;
            alu_rd_wdata_o <= '0;
            op_q           <= OP_ADD;
            a_q            <= '0;
            b_q            <= '0;
            mul_cnt        <= '0;
        end else if (flush_i) begin
            state       <= ST_IDLE;
            out_valid_o <= 1'b0;
            alu_rd_we_o <= 1'b0;
            mul_cnt     <= '0;
        end else if (accept) begin
            op_q           <= operate_i;
            a_q            <= operand_a_i;
            b_q            <= operand_b_i;
            alu_rd_waddr_o <= rd_addr_i;
            alu_rd_we_o    <= rd_we_i;
            if (is_mul(operate_i)) begin
                if (MUL_LAT == 1) begin
                    state          <= ST_DONE;
                    out_valid_o    <= 1'b1;
                    alu_rd_wdata_o <= mul_res;
                end else begin
                    state       <= ST_MUL;
                    out_valid_o <= 1'b0;
                    mul_cnt     <= 3'(MUL_LAT - 1);
                end
            end else if (is_div(operate_i)) begin
                if (div_early) begin
                    state          <= ST_DONE;
                    out_valid_o    <= 1'b1;
                    alu_rd_wdata_o <= div_early_res;
                end else begin
                    state       <= ST_DIV;
                    out_valid_o <= 1'b0;
                end
            end else begin
                state          <= ST_DONE;
                out_valid_o    <= 1'b1;
                alu_rd_wdata_o <= alu_res;
                alu_rd_we_o    <= rd_we_i && alu_op_ok;
            end
        end else begin
            case (state)
                ST_MUL: begin
                    mul_cnt <= mul_cnt - 3'd1;
                    if (mul_cnt == 3'd1) begin
                        state          <= ST_DONE;
                        out_valid_o    <= 1'b1;
                        alu_rd_wdata_o <= mul_res;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state          <= ST_DONE;
                        out_valid_o    <= 1'b1;
                        alu_rd_wdata_o <= div_fix(op_q, a_q, b_q, div_quot, div_rem);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state       <= ST_IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32, MUL_LAT=2): vector table, handshake sequences, random ops vs a reference model.
// Honours ALU_MDU_DIV_EARLY_EN for the expected divide latency.
module tb_alu_mdu;
    import milano_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = XLEN + 1;
`ifdef ALU_MDU_DIV_EARLY_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = DIV_LAT;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    alu_mdu_op_e     operate;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic            out_valid;
    logic            out_ready;
    logic            wb_we;
    logic [4:0]      wb_waddr;
    logic [XLEN-1:0] wb_wdata;
    logic            busy;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .operate_i      (operate),
        .operand_a_i    (op_a),
        .operand_b_i    (op_b),
        .instr_addr_i   (pc),
        .rd_addr_i      (rd_addr),
        .rd_we_i        (rd_we),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .alu_rd_we_o    (wb_we),
        .alu_rd_waddr_o (wb_waddr),
        .alu_rd_wdata_o (wb_wdata),
        .busy_o         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: straight arithmetic on 64-bit integers
    function automatic logic op_defined(alu_mdu_op_e op);
        return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR,
                          OP_AND, OP_AUIPC, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV,
                          OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic [31:0] ref_model(alu_mdu_op_e op, logic [31:0] a, logic [31:0] b,
                                              logic [31:0] addr);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b[4:0]);
        case (op)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_SLL:    return 32'(ua << sh);
            OP_SRL:    return 32'(ua >> sh);
            OP_SRA:    return 32'(sa >>> sh);
            OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
            OP_XOR:    return a ^ b;
            OP_OR:     return a | b;
            OP_AND:    return a & b;
            OP_AUIPC:  return a + addr;
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            OP_REMU:   return (b == 32'd0) ? a : 32'(ua % ub);
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(alu_mdu_op_e op, logic [31:0] a, logic [31:0] b);
        longint ma;
        longint mb;
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return MUL_LAT;
        if (op inside {OP_DIV, OP_REM}) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
        end
        if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})
            return (mb == 0 || ma < mb) ? EARLY_LAT : DIV_LAT;
        return 1;
    endfunction

    // Issue one op with writeback stalled, measure latency, hold `hold` cycles, then release
    task automatic run_op(string name, alu_mdu_op_e op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] addr, logic [4:0] rd, logic we, logic [31:0] exp_d,
                          int exp_l, int hold);
        int   lat;
        logic exp_we;
        exp_we = we && op_defined(op);
        @(negedge clk);
        out_ready = 1'b0;
        operate   = op;
        op_a      = a;
        op_b      = b;
        pc        = addr;
        rd_addr   = rd;
        rd_we     = we;
        in_valid  = 1'b1;
        check({name, " in_ready idle"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_l));
        check({name, " data"}, 64'(wb_wdata), 64'(exp_d));
        check({name, " waddr"}, 64'(wb_waddr), 64'(rd));
        check({name, " we"}, 64'(wb_we), 64'(exp_we));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " held valid"}, 64'(out_valid), 64'd1);
            check({name, " held data"}, 64'(wb_wdata), 64'(exp_d));
            check({name, " held waddr"}, 64'(wb_waddr), 64'(rd));
            check({name, " stalled in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check({name, " release in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " valid after release"}, 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        alu_mdu_op_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] addr;
        logic [31:0] exp_d;
        int          exp_l;
    } vec_t;

    vec_t vecs[$];

    alu_mdu_op_e rand_ops[19] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                                  OP_OR, OP_AND, OP_AUIPC, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                  OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic        seen;
        alu_mdu_op_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] addr;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        operate   = OP_ADD;
        op_a      = '0;
        op_b      = '0;
        pc        = '0;
        rd_addr   = '0;
        rd_we     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset we", 64'(wb_we), 64'd0);
        check("reset waddr", 64'(wb_waddr), 64'd0);
        check("reset wdata", 64'(wb_wdata), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle in_ready", 64'(in_ready), 64'd1);

        // Back-to-back single-cycle ops at full throughput
        out_ready = 1'b1;
        operate   = OP_ADD;
        op_a      = 32'hFFFF_FFFF;
        op_b      = 32'd1;
        rd_addr   = 5'd5;
        rd_we     = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("b2b add valid", 64'(out_valid), 64'd1);
        check("b2b add data", 64'(wb_wdata), 64'h0);
        check("b2b add waddr", 64'(wb_waddr), 64'd5);
        check("b2b in_ready", 64'(in_ready), 64'd1);
        operate = OP_SRA;
        op_a    = 32'h8000_0000;
        op_b    = 32'd4;
        rd_addr = 5'd6;
        @(negedge clk);
        check("b2b sra valid", 64'(out_valid), 64'd1);
        check("b2b sra data", 64'(wb_wdata), 64'hF800_0000);
        check("b2b sra waddr", 64'(wb_waddr), 64'd6);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        vecs.push_back('{OP_ADD,    32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1});
        vecs.push_back('{OP_SUB,    32'h5,         32'h3,         32'h0,         32'h2,         1});
        vecs.push_back('{OP_SRA,    32'h8000_0000, 32'h4,         32'h0,         32'hF800_0000, 1});
        vecs.push_back('{OP_SRL,    32'h8000_0000, 32'h4,         32'h0,         32'h0800_0000, 1});
        vecs.push_back('{OP_SLL,    32'h1,         32'd31,        32'h0,         32'h8000_0000, 1});
        vecs.push_back('{OP_SLL,    32'h1,         32'h23,        32'h0,         32'h8,         1});
        vecs.push_back('{OP_SLT,    32'hFFFF_FFFF, 32'h1,         32'h0,         32'h1,         1});
        vecs.push_back('{OP_SLTU,   32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1});
        vecs.push_back('{OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'h0FF0_0FF0, 1});
        vecs.push_back('{OP_OR,     32'h0F0,       32'hF00,       32'h0,         32'hFF0,       1});
        vecs.push_back('{OP_AND,    32'hFF0,       32'h0F0,       32'h0,         32'h0F0,       1});
        vecs.push_back('{OP_AUIPC,  32'h0001_2000, 32'h0,         32'h8000_0004, 32'h8001_2004, 1});
        vecs.push_back('{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         MUL_LAT});
        vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, MUL_LAT});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'h2,         32'h0,         32'hFFFF_FFFF, MUL_LAT});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFE, MUL_LAT});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'h0,         32'hFFFF_FFFD, DIV_LAT});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h2,         32'h0,         32'hFFFF_FFFF, DIV_LAT});
        vecs.push_back('{OP_DIVU,   32'h1234,      32'h0,         32'h0,         32'hFFFF_FFFF, EARLY_LAT});
        vecs.push_back('{OP_REM,    32'h5,         32'h0,         32'h0,         32'h5,         EARLY_LAT});
        vecs.push_back('{OP_REMU,   32'h9,         32'h0,         32'h0,         32'h9,         EARLY_LAT});
        vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DIV_LAT});
        vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         DIV_LAT});
        vecs.push_back('{OP_DIVU,   32'd3,         32'd10,        32'h0,         32'h0,         EARLY_LAT});
        vecs.push_back('{OP_REMU,   32'd3,         32'd10,        32'h0,         32'h3,         EARLY_LAT});
        vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         32'h0,         32'd14,        DIV_LAT});
        vecs.push_back('{OP_REMU,   32'd100,       32'd7,         32'h0,         32'd2,         DIV_LAT});

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d %s", i, vecs[i].op.name()), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].addr, 5'(i + 1), 1'b1, vecs[i].exp_d, vecs[i].exp_l, 0);
        end

        // Writeback stall on SUB, then an undefined opcode
        run_op("stall sub", OP_SUB, 32'd5, 32'd3, 32'd0, 5'd9, 1'b1, 32'd2, 1, 4);
        op = alu_mdu_op_e'(5'd31);
        run_op("undef op", op, 32'h1234_5678, 32'h1, 32'd0, 5'd10, 1'b1, 32'd0, 1, 1);

        // Flush in the 10th cycle of a divide, with a competing in_valid
        @(negedge clk);
        operate  = OP_DIV;
        op_a     = 32'd100;
        op_b     = 32'd7;
        rd_addr  = 5'd11;
        rd_we    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("div busy before flush", 64'(busy), 64'd1);
        flush    = 1'b1;
        operate  = OP_ADD;
        in_valid = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush we", 64'(wb_we), 64'd0);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no write after flush", 64'(seen), 64'd0);
        out_ready = 1'b0;

        // Reset in the middle of a divide
        operate  = OP_DIVU;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        rd_addr  = 5'd12;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-div reset busy", 64'(busy), 64'd0);
        check("mid-div reset wdata", 64'(wb_wdata), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no result after reset", 64'(seen), 64'd0);

        // Random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) op = alu_mdu_op_e'(5'($urandom_range(24, 31)));
            else op = rand_ops[$urandom_range(0, 18)];
            a    = rnd_val();
            b    = rnd_val();
            addr = $urandom();
            run_op($sformatf("rnd%0d %s", n, op.name()), op, a, b, addr,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   ref_model(op, a, b, addr), ref_lat(op, a, b), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
